vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock, 50 MHz; every register uses its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 x  output  10  current pixel column, 0..799.
REQ-005 y  output  10  current pixel row, 0..524.
REQ-006 video_on  output  1  high while x<640 and y<480 (visible area).
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 p_tick  output  1  one-clk pulse, every 2nd clk, marks a pixel advance (25 MHz).
REQ-010 frame_tick  output  1  one-clk pulse at the last pixel of each frame.

Function
REQ-011 A 1-bit divider SHALL toggle every clk; p_tick = divider==1, giving the pattern 0,1,0,1... after reset.
REQ-012 On a clk edge where p_tick=1, the horizontal counter SHALL increment; at 799 it SHALL wrap to 0 and advance the vertical counter.
REQ-013 The vertical counter SHALL increment only on the horizontal wrap; at 524 it SHALL wrap to 0.
REQ-014 Both counters SHALL hold their value on edges where p_tick=0.
REQ-015 x and y SHALL be the registered horizontal and vertical counters directly, with no added latency.
REQ-016 hsync SHALL be 0 when x is in 656..751 inclusive, and 1 otherwise.
REQ-017 vsync SHALL be 0 when y is in 490..491 inclusive, and 1 otherwise.
REQ-018 video_on, hsync and vsync SHALL be decoded from the registered counters, so they are aligned with x/y in the same cycle.
REQ-019 frame_tick SHALL be 1 only when p_tick=1, x=799 and y=524, i.e. on the cycle before the wrap to (0,0).
REQ-020 One line SHALL last 800 pixel ticks (1600 clk); one frame SHALL last 420000 pixel ticks (840000 clk).
REQ-021 All counter arithmetic SHALL be 10-bit unsigned; no value outside the stated ranges SHALL ever appear.
REQ-022 Downstream glyph renderers consume x,y,video_on combinationally; their disp output is qualified by video_on.

Reset
REQ-023 While rst=1, divider, x and y SHALL be 0, which gives p_tick=0, frame_tick=0, hsync=1, vsync=1 and video_on=1.
REQ-024 If rst is asserted mid-line or mid-frame, the counters SHALL clear immediately without waiting for a clock edge.
REQ-025 After rst deasserts, the first p_tick SHALL occur on the 2nd clk edge, and x SHALL become 1 on that edge.

Structure
REQ-026 Package vga_pkg SHALL hold these constants: H_DISPLAY=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_DISPLAY=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525.
REQ-027 All sync, wrap and visibility bounds SHALL be derived from vga_pkg constants, with no literals in the RTL.
REQ-028 A sub-module mod_counter SHALL be used: a 10-bit counter with a parameterised modulus, an enable input and a wrap output.
REQ-029 mod_counter SHALL be instantiated twice: horizontal (enable=p_tick) and vertical (enable=horizontal wrap).

Verification
REQ-030 Reset release: rst 1->0 -> p_tick is 0,1,0,1 on successive clks; x steps 0,0,1,1,2 on clk edges 0..4; y=0.
REQ-031 Line wrap: run to x=799,y=0, then one p_tick -> x=0,y=1; hsync is 0 for exactly 96 pixel ticks (x 656..751) on each line.
REQ-032 Frame wrap: run to x=799,y=524 -> frame_tick=1 for exactly one clk; next edge x=0,y=0; frame_tick period is 840000 clk.
REQ-033 vsync: vsync=0 exactly for y=490 and y=491, i.e. 1600 pixel ticks (3200 clk) per frame.
REQ-034 video_on: 1 at (639,479), 0 at (640,0) and at (0,480); 307200 high pixel ticks per frame.
REQ-035 Mid-frame reset: assert rst at x=300,y=200 between edges -> x,y=0 and hsync=vsync=1 immediately; after release, timing restarts per REQ-030.

Source files
------------

// File: rtl/vga_sync_pkg.sv
// 640x480@60 VGA timing constants and the counter width shared by the sync generator.
// Pure constants; no logic or latency.
package vga_pkg;
  localparam int CNT_W     = 10;
  localparam int H_DISPLAY = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_DISPLAY = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
endpackage

// File: rtl/vga_sync_if.sv
// Raster position and sync bundle from the timing generator to pixel consumers.
// Free-running outputs, no handshake; consumers sample x/y/video_on combinationally.
interface vga_sync_if;
  import vga_pkg::*;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             video_on;
  logic             hsync;
  logic             vsync;
  logic             p_tick;
  logic             frame_tick;

  modport master (output x, y, video_on, hsync, vsync, p_tick, frame_tick);
  modport slave  (input  x, y, video_on, hsync, vsync, p_tick, frame_tick);
endinterface

// File: rtl/vga_sync_mod_counter.sv
// Modulo-MOD up-counter with enable; wrap is combinational and high on the enabled terminal count.
// Count updates one clk after en; no backpressure.
module mod_counter
  import vga_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == CNT_W'(MOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA raster generator: clk/2 pixel tick, x/y counters and sync/visibility decode from them.
// Decoded outputs share the cycle of the registered counters; free-running, no backpressure.
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_DISP   = H_DISPLAY,
  parameter int H_FRONT  = H_FP,
  parameter int H_SYNC_W = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_DISP   = V_DISPLAY,
  parameter int V_FRONT  = V_FP,
  parameter int V_SYNC_W = V_SYNC,
  parameter int V_BACK   = V_BP
) (
  input  logic        clk,
  input  logic        rst,
  vga_sync_if.master  vga
);

  localparam int H_TOT     = H_DISP + H_FRONT + H_SYNC_W + H_BACK;
  localparam int V_TOT     = V_DISP + V_FRONT + V_SYNC_W + V_BACK;
  localparam int H_SYNC_LO = H_DISP + H_FRONT;
  localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC_W - 1;
  localparam int V_SYNC_LO = V_DISP + V_FRONT;
  localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC_W - 1;

  logic             div;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= 1'b0;
    end else begin
      div <= ~div;
    end
  end

  mod_counter #(.MOD(H_TOT)) u_h_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (div),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  // Vertical only moves on the horizontal wrap, so its wrap already implies the last pixel of the frame.
  mod_counter #(.MOD(V_TOT)) u_v_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  assign vga.x          = h_cnt;
  assign vga.y          = v_cnt;
  assign vga.p_tick     = div;
  assign vga.frame_tick = v_wrap;
  assign vga.video_on   = (h_cnt < CNT_W'(H_DISP)) && (v_cnt < CNT_W'(V_DISP));
  assign vga.hsync      = !((h_cnt >= CNT_W'(H_SYNC_LO)) && (h_cnt <= CNT_W'(H_SYNC_HI)));
  assign vga.vsync      = !((v_cnt >= CNT_W'(V_SYNC_LO)) && (v_cnt <= CNT_W'(V_SYNC_HI)));

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench: full-size timing instance for line behaviour, reduced-timing instance for frame behaviour.
module tb_vga_sync;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       p_tick;
    logic       frame_tick;
  } obs_t;

  // reduced timing for the second instance so whole frames fit in a short run
  localparam int S_HD = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VD = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  vga_sync_if vif_d ();
  vga_sync_if vif_s ();

  vga_sync dut (.clk(clk), .rst(rst_d), .vga(vif_d));

  vga_sync #(
    .H_DISP(S_HD), .H_FRONT(S_HF), .H_SYNC_W(S_HS), .H_BACK(S_HB),
    .V_DISP(S_VD), .V_FRONT(S_VF), .V_SYNC_W(S_VS), .V_BACK(S_VB)
  ) dut_s (.clk(clk), .rst(rst_s), .vga(vif_s));

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  obs_t q_d[$];
  obs_t q_s[$];

  // t = rising edges since reset release; two edges per pixel, pixels laid out row-major
  function automatic obs_t model(int t, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb);
    obs_t o;
    int ht = hd + hf + hs + hb;
    int vt = vd + vf + vs + vb;
    int pix = t / 2;
    int px = pix % ht;
    int py = (pix / ht) % vt;
    o.x          = 10'(px);
    o.y          = 10'(py);
    o.p_tick     = (t % 2) == 1;
    o.video_on   = (px < hd) && (py < vd);
    o.hsync      = !((px >= hd + hf) && (px < hd + hf + hs));
    o.vsync      = !((py >= vd + vf) && (py < vd + vf + vs));
    o.frame_tick = o.p_tick && (px == ht - 1) && (py == vt - 1);
    return o;
  endfunction

  function automatic obs_t snap(logic [9:0] x, logic [9:0] y, logic v, logic hs,
                                logic vs, logic pt, logic ft);
    obs_t o;
    o.x = x; o.y = y; o.video_on = v; o.hsync = hs; o.vsync = vs;
    o.p_tick = pt; o.frame_tick = ft;
    return o;
  endfunction

  task automatic check_obs(string name, obs_t a, obs_t e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s @%0t got x=%0d y=%0d von=%b hs=%b vs=%b pt=%b ft=%b exp x=%0d y=%0d von=%b hs=%b vs=%b pt=%b ft=%b",
                  name, $time, a.x, a.y, a.video_on, a.hsync, a.vsync, a.p_tick, a.frame_tick,
                  e.x, e.y, e.video_on, e.hsync, e.vsync, e.p_tick, e.frame_tick);
  endtask

  task automatic check_int(string name, int a, int e);
    n_checks++;
    if (a == e) n_pass++;
    else $display("FAIL %s @%0t got %0d exp %0d", name, $time, a, e);
  endtask

  // stimulus side: predict each cycle's outputs and queue them
  int t_d = 0;
  int t_s = 0;
  always @(posedge clk) begin
    if (rst_d) t_d = 0; else t_d++;
    if (rst_s) t_s = 0; else t_s++;
    #1;
    q_d.push_back(model(t_d, 640, 16, 96, 48, 480, 10, 2, 33));
    q_s.push_back(model(t_s, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB));
  end

  // monitors: pop and compare, plus per-line / per-frame aggregate checks
  int  l_clk = 0, l_hs = 0;
  bit  l_ok = 1'b0;
  always @(negedge clk) begin
    obs_t a, e;
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      a = snap(vif_d.x, vif_d.y, vif_d.video_on, vif_d.hsync, vif_d.vsync,
               vif_d.p_tick, vif_d.frame_tick);
      check_obs("cyc_full", a, e);
      if (rst_d) begin
        l_ok = 1'b0; l_clk = 0; l_hs = 0;
      end else begin
        l_clk++;
        if (a.p_tick && !a.hsync) l_hs++;
        if (a.p_tick && a.x == 10'd799) begin
          if (l_ok) begin
            check_int("line_clk", l_clk, 1600);
            check_int("line_hsync_px", l_hs, 96);
          end
          l_ok = 1'b1; l_clk = 0; l_hs = 0;
        end
      end
    end
  end

  int  f_clk = 0, f_vs = 0, f_hs = 0, f_von = 0;
  bit  f_ok = 1'b0;
  always @(negedge clk) begin
    obs_t a, e;
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      a = snap(vif_s.x, vif_s.y, vif_s.video_on, vif_s.hsync, vif_s.vsync,
               vif_s.p_tick, vif_s.frame_tick);
      check_obs("cyc_small", a, e);
      if (rst_s) begin
        f_ok = 1'b0; f_clk = 0; f_vs = 0; f_hs = 0; f_von = 0;
      end else begin
        f_clk++;
        if (a.p_tick && !a.vsync) f_vs++;
        if (a.p_tick && !a.hsync) f_hs++;
        if (a.p_tick && a.video_on) f_von++;
        if (a.frame_tick) begin
          if (f_ok) begin
            check_int("frame_clk", f_clk, 2 * S_HT * S_VT);
            check_int("frame_vsync_px", f_vs, S_VS * S_HT);
            check_int("frame_hsync_px", f_hs, S_HS * S_VT);
            check_int("frame_video_px", f_von, S_HD * S_VD);
          end
          f_ok = 1'b1; f_clk = 0; f_vs = 0; f_hs = 0; f_von = 0;
        end
      end
    end
  end

  task automatic drive_full;
    int guard;
    repeat (3) @(negedge clk);
    #2 rst_d = 1'b0;
    repeat (8 * 1600 + $urandom_range(0, 1599)) @(negedge clk);
    guard = 0;
    while (vif_d.x != 10'd300 && guard < 1700) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1700) check_int("wait_x300_timeout", guard, 0);
    #2 rst_d = 1'b1;
    #1 check_obs("async_rst_full",
                 snap(vif_d.x, vif_d.y, vif_d.video_on, vif_d.hsync, vif_d.vsync,
                      vif_d.p_tick, vif_d.frame_tick),
                 model(0, 640, 16, 96, 48, 480, 10, 2, 33));
    repeat ($urandom_range(1, 4)) @(negedge clk);
    #2 rst_d = 1'b0;
    repeat (20 * 1600) @(negedge clk);
  endtask

  task automatic drive_small;
    repeat (2) @(negedge clk);
    #2 rst_s = 1'b0;
    repeat (3 * 2 * S_HT * S_VT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(50, 2 * S_HT * S_VT)) @(negedge clk);
      #2 rst_s = 1'b1;
      #1 check_obs("async_rst_small",
                   snap(vif_s.x, vif_s.y, vif_s.video_on, vif_s.hsync, vif_s.vsync,
                        vif_s.p_tick, vif_s.frame_tick),
                   model(0, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst_s = 1'b0;
    end
    repeat (3 * 2 * S_HT * S_VT) @(negedge clk);
  endtask

  initial begin
    fork
      drive_full();
      drive_small();
    join
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
